// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Imported by dff_pipe; holds the depth bounds and occupancy width helper.
package dff_pipe_pkg;

   localparam int DEPTH_MIN = 1;
   localparam int DEPTH_MAX = 16;

   // Bits needed to count 0..depth inclusive
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One v/d register pair of the elastic pipeline.
// Ready is ~v | dst_rdy so an empty stage always accepts (bubble collapse).
module dff_pipe_stage #(
   parameter int             DW     = 8,
   parameter logic [DW-1:0]  RST_VL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          src_vld,
   input  logic [DW-1:0] src_data,
   input  logic          dst_rdy,
   output logic          v,
   output logic [DW-1:0] d,
   output logic          rdy
);

   logic          v_q;
   logic          v_d;
   logic [DW-1:0] d_q;
   logic [DW-1:0] d_d;
   logic          ld;

   assign rdy = ~v_q | dst_rdy;
   assign ld  = src_vld & rdy & ~flush;

   // Load on accept, otherwise hold; flush drops valid but keeps data
   always_comb begin
      v_d = ld | (v_q & ~dst_rdy);
      d_d = d_q;
      if (ld) begin
         d_d = src_data;
      end
      if (flush) begin
         v_d = 1'b0;
      end
   end

   // Stage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= RST_VL;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/dff_pipe.sv
// Parametrised elastic register pipeline with valid/ready and occupancy.
// Optional flush port enabled by defining DFF_PIPE_FLUSH_EN.
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int             DW     = 8,
   parameter int             DEPTH  = 2,
   parameter logic [DW-1:0]  RST_VL = '0,
   parameter int             CW     = occ_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] occ
`ifdef DFF_PIPE_FLUSH_EN
   ,
   input  logic          flush
`endif
);

`ifndef DFF_PIPE_FLUSH_EN
   logic flush;
   assign flush = 1'b0;
`endif

   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("dff_pipe: DEPTH out of range 1..16");
   end

   // Each stage keeps its own scalar ready wire so the
   // ready chain is not seen as a self-loop on one vector.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      logic          v_w;
      logic [DW-1:0] d_w;
      logic          rdy_w;
      logic          src_v;
      logic [DW-1:0] src_d;
      logic          dst_r;

      if (k == 0) begin : g_src_in
         assign src_v = in_vld;
         assign src_d = in_data;
      end else begin : g_src_stg
         assign src_v = g_stg[k-1].v_w;
         assign src_d = g_stg[k-1].d_w;
      end

      if (k == DEPTH - 1) begin : g_dst_out
         assign dst_r = out_rdy;
      end else begin : g_dst_stg
         assign dst_r = g_stg[k+1].rdy_w;
      end

      dff_pipe_stage #(
         .DW     (DW),
         .RST_VL (RST_VL)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .src_vld  (src_v),
         .src_data (src_d),
         .dst_rdy  (dst_r),
         .v        (v_w),
         .d        (d_w),
         .rdy      (rdy_w)
      );
   end

   assign in_rdy   = g_stg[0].rdy_w & ~flush;
   assign out_vld  = g_stg[DEPTH-1].v_w & ~flush;
   assign out_data = g_stg[DEPTH-1].d_w;

   logic          in_xfer;
   logic          out_xfer;
   logic [CW-1:0] occ_q;
   logic [CW-1:0] occ_d;

   assign in_xfer  = in_vld & in_rdy;
   assign out_xfer = out_vld & out_rdy;

   // Occupancy tracks accepted minus delivered words
   always_comb begin
      occ_d = occ_q + CW'(in_xfer) - CW'(out_xfer);
      if (flush) begin
         occ_d = '0;
      end
   end

   // Occupancy register
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;

   a_occ_bound : assert property (
      @(posedge clk) disable iff (rst) occ_q <= CW'(DEPTH)
   );

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (DW=8, DEPTH=3).
// Table vectors, directed sequences and a queue-based random model.
module tb_dff_pipe;

   localparam int DW    = 8;
   localparam int DEPTH = 3;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_vld;
   logic          in_rdy;
   logic [DW-1:0] in_data;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] out_data;
   logic [CW-1:0] occ;
`ifdef DFF_PIPE_FLUSH_EN
   logic          flush;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dff_pipe #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .RST_VL (8'h00)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .occ      (occ)
`ifdef DFF_PIPE_FLUSH_EN
      ,
      .flush    (flush)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit iv, input logic [7:0] id,
                        input bit ordy);
      @(negedge clk);
      in_vld  = iv;
      in_data = id;
      out_rdy = ordy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      in_vld  = 1'b1;
      in_data = 8'hFF;
      out_rdy = 1'b1;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      in_vld  = 1'b0;
      out_rdy = 1'b0;
   endtask

   // Reference model: queue of words with their stage positions
   int mq_d[$];
   int mq_p[$];
   int m_last;

   function automatic void m_reset();
      mq_d.delete();
      mq_p.delete();
      m_last = 0;
   endfunction

   function automatic bit m_out_vld();
      return (mq_p.size() > 0) && (mq_p[0] == DEPTH - 1);
   endfunction

   function automatic bit m_tick(input bit ordy, input bit ivld,
                                 input int idat, input bit commit);
      int p[$];
      int d[$];
      bit rdy;
      p = mq_p;
      d = mq_d;
      if (p.size() > 0 && p[0] == DEPTH - 1 && ordy) begin
         void'(p.pop_front());
         void'(d.pop_front());
      end
      for (int i = 0; i < p.size(); i++) begin
         int lim;
         lim  = (i == 0) ? DEPTH - 1 : p[i-1] - 1;
         p[i] = (p[i] + 1 < lim) ? p[i] + 1 : lim;
      end
      rdy = (p.size() == 0) || (p[p.size()-1] > 0);
      if (commit) begin
         if (ivld && rdy) begin
            p.push_back(0);
            d.push_back(idat);
         end
         if (p.size() > 0 && p[0] == DEPTH - 1) m_last = d[0];
         mq_p = p;
         mq_d = d;
      end
      return rdy;
   endfunction

   typedef struct {
      bit         iv;
      logic [7:0] id;
      bit         ordy;
      bit         e_irdy;
      bit         e_ovld;
      logic [7:0] e_od;
      int         e_occ;
   } vec_t;

   vec_t tbl[14];

   initial begin
      bit         iv;
      bit         ordy;
      logic [7:0] id;
      bit         e_rdy;

      tbl[0]  = '{1, 8'hA5, 0, 1, 0, 8'h00, 0};
      tbl[1]  = '{0, 8'h00, 0, 1, 0, 8'h00, 1};
      tbl[2]  = '{0, 8'h00, 0, 1, 0, 8'h00, 1};
      tbl[3]  = '{1, 8'h5A, 0, 1, 1, 8'hA5, 1};
      tbl[4]  = '{0, 8'h00, 0, 1, 1, 8'hA5, 2};
      tbl[5]  = '{0, 8'h00, 0, 1, 1, 8'hA5, 2};
      tbl[6]  = '{1, 8'h33, 0, 1, 1, 8'hA5, 2};
      tbl[7]  = '{1, 8'h44, 0, 0, 1, 8'hA5, 3};
      tbl[8]  = '{1, 8'h44, 1, 1, 1, 8'hA5, 3};
      tbl[9]  = '{0, 8'h00, 1, 1, 1, 8'h5A, 3};
      tbl[10] = '{0, 8'h00, 1, 1, 1, 8'h33, 2};
      tbl[11] = '{0, 8'h00, 0, 1, 1, 8'h44, 1};
      tbl[12] = '{0, 8'h00, 1, 1, 1, 8'h44, 1};
      tbl[13] = '{0, 8'h00, 1, 1, 0, 8'h44, 0};

      rst     = 1'b1;
      in_vld  = 1'b0;
      in_data = '0;
      out_rdy = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
      flush   = 1'b0;
`endif

      // Reset with junk on the inputs
      do_reset();
      drive(0, 8'h00, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_occ", occ, 0);
      chk("rst_in_rdy", in_rdy, 1);

      // Table vectors: bubble collapse, stall, simultaneous, drain
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].iv, tbl[i].id, tbl[i].ordy);
         chk($sformatf("tbl%0d_in_rdy", i), in_rdy, tbl[i].e_irdy);
         chk($sformatf("tbl%0d_out_vld", i), out_vld, tbl[i].e_ovld);
         chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("tbl%0d_occ", i), occ, tbl[i].e_occ);
      end

      // Back-to-back stream 0x01..0x0A, latency DEPTH cycles
      do_reset();
      for (int c = 0; c < 14; c++) begin
         drive(c < 10, 8'(c + 1), 1);
         chk($sformatf("strm%0d_in_rdy", c), in_rdy, 1);
         chk($sformatf("strm%0d_out_vld", c), out_vld,
             (c >= 3 && c < 13));
         if (c >= 3 && c < 13)
            chk($sformatf("strm%0d_out_data", c), out_data, c - 2);
      end

      // Stall: full pipe with out_rdy low, then one pop
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, 8'(8'h11 + i), 0);
      for (int i = 0; i < 2; i++) begin
         drive(1, 8'h99, 0);
         chk("stall_occ", occ, 3);
         chk("stall_in_rdy", in_rdy, 0);
         chk("stall_out_vld", out_vld, 1);
         chk("stall_out_data", out_data, 8'h11);
      end
      drive(0, 8'h00, 1);
      chk("pop_in_rdy", in_rdy, 1);
      drive(0, 8'h00, 0);
      chk("pop_occ", occ, 2);
      chk("pop_in_rdy2", in_rdy, 1);
      chk("pop_out_data", out_data, 8'h12);

      // Simultaneous push/pop on a full pipe
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, 8'(8'h21 + i), 0);
      for (int j = 0; j < 5; j++) begin
         drive(1, 8'(8'h24 + j), 1);
         chk($sformatf("sim%0d_occ", j), occ, 3);
         chk($sformatf("sim%0d_in_rdy", j), in_rdy, 1);
         chk($sformatf("sim%0d_out_vld", j), out_vld, 1);
         chk($sformatf("sim%0d_out_data", j), out_data, 8'h21 + j);
      end
      for (int j = 0; j < 3; j++) begin
         drive(0, 8'h00, 1);
         chk($sformatf("drn%0d_occ", j), occ, 3 - j);
         chk($sformatf("drn%0d_out_data", j), out_data, 8'h26 + j);
      end
      drive(0, 8'h00, 1);
      chk("drn_empty_vld", out_vld, 0);
      chk("drn_empty_occ", occ, 0);

`ifdef DFF_PIPE_FLUSH_EN
      // Flush a full pipe, then reset and flush together
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, 8'(8'h71 + i), 0);
      @(negedge clk);
      flush   = 1'b1;
      in_vld  = 1'b1;
      out_rdy = 1'b1;
      #1;
      chk("fl_in_rdy", in_rdy, 0);
      chk("fl_out_vld", out_vld, 0);
      chk("fl_occ_before", occ, 3);
      @(negedge clk);
      flush   = 1'b0;
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      #1;
      chk("fl_occ", occ, 0);
      chk("fl_in_rdy_next", in_rdy, 1);
      chk("fl_out_vld_next", out_vld, 0);
      chk("fl_data_hold", out_data, 8'h71);
      for (int i = 0; i < 3; i++) drive(1, 8'(8'h81 + i), 0);
      @(negedge clk);
      rst    = 1'b1;
      flush  = 1'b1;
      in_vld = 1'b0;
      @(negedge clk);
      rst    = 1'b0;
      flush  = 1'b0;
      #1;
      chk("rstfl_out_data", out_data, 8'h00);
      chk("rstfl_occ", occ, 0);
      chk("rstfl_in_rdy", in_rdy, 1);
`endif

      // Random traffic against the queue model
      do_reset();
      m_reset();
      for (int c = 0; c < 400; c++) begin
         iv   = ($urandom_range(0, 99) < 60);
         ordy = ($urandom_range(0, 99) < 55);
         id   = 8'($urandom);
         drive(iv, id, ordy);
         e_rdy = m_tick(ordy, iv, int'(id), 0);
         chk("rnd_in_rdy", in_rdy, e_rdy);
         chk("rnd_out_vld", out_vld, m_out_vld());
         chk("rnd_out_data", out_data, m_last);
         chk("rnd_occ", occ, mq_p.size());
         void'(m_tick(ordy, iv, int'(id), 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
